draw_paddles: RTL and testbench

- Parametrised successor to the single-stage racket drawer.
- Overlays two player paddles (left, right) on the incoming pixel stream.
- Paddle positions are double-buffered per frame, so a paddle never tears mid-frame. Positions are clamped to the visible area.
- Each paddle can flash in an alternate colour for a programmable number of frames after a ball hit.
- Sits in the video pipeline after the background/ball drawers and before the VGA output register.

---
 rtl/draw_paddles_pkg.sv | 25 ++
 rtl/draw_paddles_paddle_state.sv | 63 ++++++
 rtl/draw_paddles.sv | 145 ++++++++++++++
 tb/tb_draw_paddles.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/draw_paddles_pkg.sv
// Shared constants and types for the paddle overlay stage.
//   - Screen geometry (active area) for the video timing in use.
//   - Default paddle geometry.
//   - 12-bit RGB pixel type and a span-membership helper.
package draw_paddles_pkg;

  localparam int unsigned SCR_H_ACTIVE = 1024;
  localparam int unsigned SCR_V_ACTIVE = 768;

  localparam int unsigned PAD_WIDTH  = 10;
  localparam int unsigned PAD_LENGTH = 80;
  localparam int unsigned PAD_XPOS_L = 50;
  localparam int unsigned PAD_XPOS_R = 963;

  typedef logic [11:0] rgb_t;

  // True when p lies in [lo, lo+len). Evaluated at 12 bits so that
  // lo+len cannot wrap for any 11-bit coordinate plus paddle size.
  function automatic logic in_span(input logic [11:0] p,
                                   input logic [11:0] lo,
                                   input logic [11:0] len);
    return (p >= lo) && (p < (lo + len));
  endfunction

endpackage

// File: rtl/draw_paddles_paddle_state.sv
// Per-paddle state: frame-latched, clamped y position and flash counter.
// Ports:
//   clk_i, rst_i  : clock, synchronous active-high reset
//   fe_i          : frame edge strobe (rising edge of vblnk)
//   hit_i         : single-cycle hit pulse, (re)loads the flash counter
//   y_pos_i       : requested paddle top line, any value
//   y_o           : latched, clamped paddle top line (12 bits)
//   flash_o       : high while the flash counter is nonzero
module draw_paddles_paddle_state
  import draw_paddles_pkg::*;
#(
  parameter int unsigned LENGTH       = PAD_LENGTH,
  parameter int unsigned V_ACTIVE     = SCR_V_ACTIVE,
  parameter int unsigned FLASH_FRAMES = 8,
  parameter int unsigned POS_W        = 11
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             fe_i,
  input  logic             hit_i,
  input  logic [POS_W-1:0] y_pos_i,
  output logic [11:0]      y_o,
  output logic             flash_o
);

  localparam logic [POS_W:0] Y_MAX    = (POS_W+1)'(V_ACTIVE - LENGTH);
  localparam logic [11:0]    Y_RST    = 12'((V_ACTIVE - LENGTH) / 2);
  localparam logic [7:0]     FLASH_LD = 8'(FLASH_FRAMES);

  logic [11:0] y_q, y_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [POS_W:0] y_ext;

  assign y_ext = {1'b0, y_pos_i};

  always_comb begin
    y_d   = y_q;
    cnt_d = cnt_q;
    if (fe_i) begin
      y_d = (y_ext > Y_MAX) ? 12'(Y_MAX) : 12'(y_ext);
    end
    // A hit coinciding with a frame edge loads without decrementing.
    if (hit_i) begin
      cnt_d = FLASH_LD;
    end else if (fe_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      y_q   <= Y_RST;
      cnt_q <= '0;
    end else begin
      y_q   <= y_d;
      cnt_q <= cnt_d;
    end
  end

  assign y_o     = y_q;
  assign flash_o = (cnt_q != '0);

endmodule

// File: rtl/draw_paddles.sv
// Overlays a left and a right paddle on the pixel stream, two-stage pipeline.
// Ports:
//   pclk, rst                  : pixel clock, synchronous active-high reset
//   hcount_in, vcount_in       : raster position
//   hsync/vsync/hblnk/vblnk_in : timing strobes
//   rgb_in                     : upstream pixel colour
//   y_pos_l, y_pos_r           : requested paddle top lines (latched per frame)
//   hit_l, hit_r               : ball-hit pulses, start the flash colour
//   color, flash_color         : normal and flash paddle colours
//   *_out                      : all inputs delayed by 2 cycles, rgb composited
module draw_paddles
  import draw_paddles_pkg::*;
#(
  parameter int unsigned WIDTH        = PAD_WIDTH,
  parameter int unsigned LENGTH       = PAD_LENGTH,
  parameter int unsigned XPOS_L       = PAD_XPOS_L,
  parameter int unsigned XPOS_R       = PAD_XPOS_R,
  parameter int unsigned V_ACTIVE     = SCR_V_ACTIVE,
  parameter int unsigned FLASH_FRAMES = 8,
  parameter int unsigned POS_W        = 11
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic [10:0]      hcount_in,
  input  logic [10:0]      vcount_in,
  input  logic             hsync_in,
  input  logic             vsync_in,
  input  logic             hblnk_in,
  input  logic             vblnk_in,
  input  logic [11:0]      rgb_in,
  input  logic [POS_W-1:0] y_pos_l,
  input  logic [POS_W-1:0] y_pos_r,
  input  logic             hit_l,
  input  logic             hit_r,
  input  logic [11:0]      color,
  input  logic [11:0]      flash_color,
  output logic [10:0]      hcount_out,
  output logic [10:0]      vcount_out,
  output logic             hsync_out,
  output logic             vsync_out,
  output logic             hblnk_out,
  output logic             vblnk_out,
  output logic [11:0]      rgb_out
);

  logic        vblnk_d_q;
  logic        fe;
  logic [11:0] y_l, y_r;
  logic        flash_l, flash_r;
  logic        in_l, in_r;

  // Stage 1
  logic [10:0] s1_hcount_q, s1_vcount_q;
  logic [3:0]  s1_sync_q;
  rgb_t        s1_rgb_q;
  logic        s1_in_l_q, s1_in_r_q;

  // Stage 2 (output register)
  logic [10:0] s2_hcount_q, s2_vcount_q;
  logic [3:0]  s2_sync_q;
  rgb_t        s2_rgb_q, s2_rgb_d;

  assign fe = vblnk_in & ~vblnk_d_q;

  draw_paddles_paddle_state #(
    .LENGTH       (LENGTH),
    .V_ACTIVE     (V_ACTIVE),
    .FLASH_FRAMES (FLASH_FRAMES),
    .POS_W        (POS_W)
  ) u_state_l (
    .clk_i   (pclk),
    .rst_i   (rst),
    .fe_i    (fe),
    .hit_i   (hit_l),
    .y_pos_i (y_pos_l),
    .y_o     (y_l),
    .flash_o (flash_l)
  );

  draw_paddles_paddle_state #(
    .LENGTH       (LENGTH),
    .V_ACTIVE     (V_ACTIVE),
    .FLASH_FRAMES (FLASH_FRAMES),
    .POS_W        (POS_W)
  ) u_state_r (
    .clk_i   (pclk),
    .rst_i   (rst),
    .fe_i    (fe),
    .hit_i   (hit_r),
    .y_pos_i (y_pos_r),
    .y_o     (y_r),
    .flash_o (flash_r)
  );

  always_comb begin
    in_l = in_span({1'b0, vcount_in}, y_l, 12'(LENGTH)) &&
           in_span({1'b0, hcount_in}, 12'(XPOS_L), 12'(WIDTH));
    in_r = in_span({1'b0, vcount_in}, y_r, 12'(LENGTH)) &&
           in_span({1'b0, hcount_in}, 12'(XPOS_R), 12'(WIDTH));
  end

  // Flash state is sampled here, at stage 2, not carried with the pixel.
  always_comb begin
    s2_rgb_d = s1_rgb_q;
    if (s1_in_l_q) begin
      s2_rgb_d = flash_l ? flash_color : color;
    end else if (s1_in_r_q) begin
      s2_rgb_d = flash_r ? flash_color : color;
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      vblnk_d_q   <= 1'b0;
      s1_hcount_q <= '0;
      s1_vcount_q <= '0;
      s1_sync_q   <= '0;
      s1_rgb_q    <= '0;
      s1_in_l_q   <= 1'b0;
      s1_in_r_q   <= 1'b0;
      s2_hcount_q <= '0;
      s2_vcount_q <= '0;
      s2_sync_q   <= '0;
      s2_rgb_q    <= '0;
    end else begin
      vblnk_d_q   <= vblnk_in;
      s1_hcount_q <= hcount_in;
      s1_vcount_q <= vcount_in;
      s1_sync_q   <= {hsync_in, vsync_in, hblnk_in, vblnk_in};
      s1_rgb_q    <= rgb_in;
      s1_in_l_q   <= in_l;
      s1_in_r_q   <= in_r;
      s2_hcount_q <= s1_hcount_q;
      s2_vcount_q <= s1_vcount_q;
      s2_sync_q   <= s1_sync_q;
      s2_rgb_q    <= s2_rgb_d;
    end
  end

  assign hcount_out = s2_hcount_q;
  assign vcount_out = s2_vcount_q;
  assign {hsync_out, vsync_out, hblnk_out, vblnk_out} = s2_sync_q;
  assign rgb_out    = s2_rgb_q;

endmodule

// File: tb/tb_draw_paddles.sv
module tb_draw_paddles;

  localparam logic [11:0] C = 12'h0F0;
  localparam logic [11:0] F = 12'hF0F;

  logic        pclk = 1'b0;
  logic        rst;
  logic [10:0] hcount_in, vcount_in;
  logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
  logic [11:0] rgb_in;
  logic [10:0] y_pos_l, y_pos_r;
  logic        hit_l, hit_r;
  logic [11:0] color, flash_color;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;
  logic [10:0] ov_hcount, ov_vcount;
  logic        ov_hs, ov_vs, ov_hb, ov_vb;
  logic [11:0] ov_rgb;

  int nchk = 0;
  int nerr = 0;

  logic [11:0] p_rgb;
  logic [10:0] p_h, p_v;
  logic [3:0]  p_sync;

  always #5 pclk = ~pclk;

  draw_paddles #(.FLASH_FRAMES(3)) dut (
    .pclk(pclk), .rst(rst), .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .y_pos_l(y_pos_l), .y_pos_r(y_pos_r), .hit_l(hit_l), .hit_r(hit_r),
    .color(color), .flash_color(flash_color), .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out)
  );

  // Second instance with both paddles in the same columns.
  draw_paddles #(.FLASH_FRAMES(3), .XPOS_R(50)) dut_ov (
    .pclk(pclk), .rst(rst), .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .y_pos_l(y_pos_l), .y_pos_r(y_pos_r), .hit_l(hit_l), .hit_r(hit_r),
    .color(color), .flash_color(flash_color), .hcount_out(ov_hcount), .vcount_out(ov_vcount),
    .hsync_out(ov_hs), .vsync_out(ov_vs), .hblnk_out(ov_hb), .vblnk_out(ov_vb),
    .rgb_out(ov_rgb)
  );

  task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
    nchk++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Apply one pixel for one cycle; the output seen after this edge belongs
  // to the previous vector (2-cycle input-to-output latency).
  task automatic vec(input int h, input int v, input logic [11:0] rgb,
                     input logic vb, input logic hl, input logic hr,
                     input logic [11:0] exp);
    hcount_in = 11'(h);
    vcount_in = 11'(v);
    hsync_in  = h[0];
    vsync_in  = v[0];
    hblnk_in  = h[1];
    vblnk_in  = vb;
    rgb_in    = rgb;
    hit_l     = hl;
    hit_r     = hr;
    @(posedge pclk);
    #1;
    chk("rgb", rgb_out, p_rgb);
    chk("hcount", {1'b0, hcount_out}, {1'b0, p_h});
    chk("vcount", {1'b0, vcount_out}, {1'b0, p_v});
    chk("sync", {8'h00, hsync_out, vsync_out, hblnk_out, vblnk_out}, {8'h00, p_sync});
    p_rgb  = exp;
    p_h    = 11'(h);
    p_v    = 11'(v);
    p_sync = {h[0], v[0], h[1], vb};
    hit_l  = 1'b0;
    hit_r  = 1'b0;
  endtask

  task automatic edge_(input logic [11:0] rgb, input logic hl);
    vec(0, 770, rgb, 1'b1, hl, 1'b0, rgb);
    vec(1, 771, rgb + 12'd1, 1'b0, 1'b0, 1'b0, rgb + 12'd1);
  endtask

  initial begin
    color = C; flash_color = F;
    y_pos_l = 11'd100; y_pos_r = 11'd100;
    hit_l = 1'b0; hit_r = 1'b0;
    hcount_in = 11'd55; vcount_in = 11'd344;
    {hsync_in, vsync_in, hblnk_in, vblnk_in} = 4'b1111;
    rgb_in = 12'hFFF;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge pclk);
      #1;
      chk("rst_rgb", rgb_out, 12'h000);
      chk("rst_cnt", {hcount_out, 1'b0} | {1'b0, vcount_out}, 12'h000);
      chk("rst_sync", {8'h00, hsync_out, vsync_out, hblnk_out, vblnk_out}, 12'h000);
    end
    vblnk_in = 1'b0;
    rst = 1'b0;
    p_rgb = '0; p_h = '0; p_v = '0; p_sync = '0;

    // Reset-centre positions (344..423), no frame edge yet.
    vec(55, 344, 12'h111, 0, 0, 0, C);
    vec(55, 343, 12'h112, 0, 0, 0, 12'h112);
    vec(55, 423, 12'h113, 0, 0, 0, C);
    vec(55, 424, 12'h114, 0, 0, 0, 12'h114);
    vec(49, 400, 12'h115, 0, 0, 0, 12'h115);
    vec(50, 400, 12'h116, 0, 0, 0, C);
    vec(59, 400, 12'h117, 0, 0, 0, C);
    vec(60, 400, 12'h118, 0, 0, 0, 12'h118);
    vec(962, 344, 12'h119, 0, 0, 0, 12'h119);
    vec(963, 344, 12'h11A, 0, 0, 0, C);
    vec(972, 423, 12'h11B, 0, 0, 0, C);
    vec(973, 423, 12'h11C, 0, 0, 0, 12'h11C);

    // Frame edge latches y_l = 100; mid-frame change is deferred.
    edge_(12'h200, 0);
    vec(55, 100, 12'h202, 0, 0, 0, C);
    y_pos_l = 11'd300;
    vec(55, 179, 12'h203, 0, 0, 0, C);
    vec(55, 180, 12'h204, 0, 0, 0, 12'h204);
    vec(55, 300, 12'h205, 0, 0, 0, 12'h205);
    edge_(12'h206, 0);
    vec(55, 299, 12'h208, 0, 0, 0, 12'h208);
    vec(55, 300, 12'h209, 0, 0, 0, C);
    vec(55, 379, 12'h20A, 0, 0, 0, C);
    vec(55, 380, 12'h20B, 0, 0, 0, 12'h20B);

    // Clamp at V_ACTIVE-LENGTH = 688.
    y_pos_r = 11'd2000;
    edge_(12'h300, 0);
    vec(965, 687, 12'h302, 0, 0, 0, 12'h302);
    vec(965, 688, 12'h303, 0, 0, 0, C);
    vec(965, 767, 12'h304, 0, 0, 0, C);
    y_pos_r = 11'd688;
    edge_(12'h310, 0);
    vec(965, 687, 12'h312, 0, 0, 0, 12'h312);
    vec(965, 688, 12'h313, 0, 0, 0, C);
    y_pos_r = 11'd687;
    edge_(12'h320, 0);
    vec(965, 686, 12'h322, 0, 0, 0, 12'h322);
    vec(965, 687, 12'h323, 0, 0, 0, C);
    vec(965, 766, 12'h324, 0, 0, 0, C);
    vec(965, 767, 12'h325, 0, 0, 0, 12'h325);

    // Flash: rest of this frame plus 2 more frames.
    vec(55, 310, 12'h400, 0, 1, 0, F);
    vec(55, 320, 12'h401, 0, 0, 0, F);
    vec(965, 700, 12'h402, 0, 0, 0, C);
    edge_(12'h410, 0);
    vec(55, 310, 12'h412, 0, 0, 0, F);
    edge_(12'h420, 0);
    vec(55, 310, 12'h422, 0, 0, 0, F);
    edge_(12'h430, 0);
    vec(55, 310, 12'h432, 0, 0, 0, C);

    // Hit coincident with frame edge loads 3; retrigger at 1 reloads 3.
    edge_(12'h500, 1);
    vec(55, 310, 12'h502, 0, 0, 0, F);
    edge_(12'h510, 0);
    vec(55, 310, 12'h512, 0, 0, 0, F);
    edge_(12'h520, 0);
    vec(55, 310, 12'h522, 0, 1, 0, F);
    edge_(12'h530, 0);
    vec(55, 310, 12'h532, 0, 0, 0, F);
    edge_(12'h540, 0);
    vec(55, 310, 12'h542, 0, 0, 0, F);
    edge_(12'h550, 0);
    vec(55, 310, 12'h552, 0, 0, 0, C);

    // Overlap: right flashing, left not; left must win.
    y_pos_r = 11'd300;
    edge_(12'h600, 0);
    vec(965, 310, 12'h602, 0, 0, 1, F);
    vec(55, 310, 12'h603, 0, 0, 0, C);
    vec(0, 0, 12'h604, 0, 0, 0, 12'h604);
    chk("overlap_left_wins", ov_rgb, C);
    vec(49, 310, 12'h605, 0, 0, 0, 12'h605);
    vec(0, 0, 12'h606, 0, 0, 0, 12'h606);
    chk("overlap_outside", ov_rgb, 12'h605);
    vec(3, 1, 12'h607, 0, 0, 0, 12'h607);

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
    $finish;
  end

endmodule
